// File: rtl/mac_ingress_arbiter.sv
// mac_ingress_arbiter: packet-granular round-robin merge of per-tenant AXI streams into the MAC parser.
// Optional build macro MAC_ARB_OVERSIZE_TRUNC_EN adds oversize truncation with an oversize_event pulse.
`default_nettype none

module mac_ingress_arbiter #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 2,
  parameter int AXIS_DEST_WIDTH   = 0,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
  localparam int NUM_PORTS        = 2 ** AXIS_ID_WIDTH,
  localparam int EFF_DEST_WIDTH   = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int ID_WIDTH         = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_PORTS*EFF_DEST_WIDTH-1:0] axis_in_tdest,
  input  logic [NUM_PORTS*NUM_BUS_BYTES-1:0]  axis_in_tkeep,
  input  logic [NUM_PORTS-1:0]                axis_in_tlast,
  input  logic [NUM_PORTS-1:0]                axis_in_tvalid,
  output logic [NUM_PORTS-1:0]                axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]           axis_out_tdata,
  output logic [NUM_BUS_BYTES-1:0]            axis_out_tkeep,
  output logic [EFF_DEST_WIDTH-1:0]           axis_out_tdest,
  output logic [NUM_PORTS-1:0]                axis_out_tuser,
  output logic [ID_WIDTH-1:0]                 axis_out_tid,
  output logic                                axis_out_tlast,
  output logic                                axis_out_tvalid,
  input  logic                                axis_out_tready,
  input  logic [NUM_PORTS-1:0]                port_enable,
  output logic                                oversize_event
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0] win_idx, scan_idx;
  logic                win_found;
  logic                sel_valid, sel_last, fwd_accept, trunc_hit;
  logic [NUM_BUS_BYTES-1:0] sel_keep;

  assign sel_valid  = axis_in_tvalid[grant_q];
  assign sel_last   = axis_in_tlast[grant_q];
  assign sel_keep   = axis_in_tkeep[grant_q*NUM_BUS_BYTES +: NUM_BUS_BYTES];
  assign fwd_accept = (state_q == FWD) && sel_valid && axis_out_tready;

  // Data path always follows the registered grant; only tvalid qualifies it.
  assign axis_out_tdata = axis_in_tdata[grant_q*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
  assign axis_out_tkeep = sel_keep;
  assign axis_out_tdest = axis_in_tdest[grant_q*EFF_DEST_WIDTH +: EFF_DEST_WIDTH];
  assign axis_out_tuser = NUM_PORTS'(1) << grant_q;
  assign axis_out_tid   = grant_q;

  // Scan downward so the candidate closest above last_grant is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      scan_idx = ID_WIDTH'((int'(last_grant_q) + i) % NUM_PORTS);
      if (axis_in_tvalid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    axis_in_tready  = '0;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = sel_last;
    oversize_event  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = port_enable[win_idx] ? FWD : DRAIN;
        end
      end
      FWD: begin
        axis_out_tvalid         = sel_valid;
        axis_in_tready[grant_q] = axis_out_tready;
        if (fwd_accept) begin
          if (sel_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else if (trunc_hit) begin
            axis_out_tlast = 1'b1;
            oversize_event = 1'b1;
            state_d        = DRAIN;
          end
        end
      end
      DRAIN: begin
        axis_in_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MAC_ARB_OVERSIZE_TRUNC_EN
  localparam int CNT_WIDTH = $clog2(MAX_PACKET_LENGTH + NUM_BUS_BYTES + 1);

  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d, keep_cnt, cnt_sum;

  always_comb begin
    keep_cnt = '0;
    for (int b = 0; b < NUM_BUS_BYTES; b++) begin
      keep_cnt = keep_cnt + CNT_WIDTH'(sel_keep[b]);
    end
    cnt_sum   = byte_cnt_q + keep_cnt;
    trunc_hit = int'(cnt_sum) >= MAX_PACKET_LENGTH;
  end

  // Held at zero outside FWD so every forwarded packet starts counting fresh.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q != FWD) begin
      byte_cnt_d = '0;
    end else if (fwd_accept) begin
      byte_cnt_d = cnt_sum;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end
`else
  logic unused_max_len;
  assign unused_max_len = ^MAX_PACKET_LENGTH;
  assign trunc_hit      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_ingress_arbiter.sv
// Directed self-checking bench for mac_ingress_arbiter (4 ports, 64-bit bus, MAX_PACKET_LENGTH=64).
`default_nettype none

module tb_mac_ingress_arbiter;
  localparam int W     = 64;
  localparam int NP    = 4;
  localparam int NB    = 8;
  localparam int DEPTH = 64;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NP*W-1:0]   in_tdata;
  logic [NP-1:0]     in_tdest;
  logic [NP*NB-1:0]  in_tkeep;
  logic [NP-1:0]     in_tlast, in_tvalid, in_tready;
  logic [W-1:0]      out_tdata;
  logic [NB-1:0]     out_tkeep;
  logic [0:0]        out_tdest;
  logic [NP-1:0]     out_tuser;
  logic [1:0]        out_tid;
  logic              out_tlast, out_tvalid, out_tready;
  logic [NP-1:0]     port_enable;
  logic              oversize_event;

  always #5 aclk = ~aclk;

  mac_ingress_arbiter #(
    .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(2), .AXIS_DEST_WIDTH(0), .MAX_PACKET_LENGTH(64)
  ) dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(in_tdata), .axis_in_tdest(in_tdest), .axis_in_tkeep(in_tkeep),
    .axis_in_tlast(in_tlast), .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tdest(out_tdest),
    .axis_out_tuser(out_tuser), .axis_out_tid(out_tid), .axis_out_tlast(out_tlast),
    .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
    .port_enable(port_enable), .oversize_event(oversize_event)
  );

  // Per-port upstream sources: beat storage with read/write pointers.
  logic [W-1:0] sd [NP][DEPTH];
  logic         sl [NP][DEPTH];
  int           wr [NP] = '{0, 0, 0, 0};
  int           rd [NP] = '{0, 0, 0, 0};
  logic [NP-1:0] take = '0;

  assign in_tkeep = '1;
  assign in_tdest = 4'b0100;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      in_tvalid[p]         = (rd[p] != wr[p]);
      in_tdata[p*W +: W]   = sd[p][rd[p] % DEPTH];
      in_tlast[p]          = sl[p][rd[p] % DEPTH];
    end
  end

  // Output monitor and per-port acceptance counters.
  logic [W-1:0] md    [DEPTH];
  logic [1:0]   mtid  [DEPTH];
  logic [NP-1:0] muser [DEPTH];
  logic         mlast [DEPTH];
  logic         mdest [DEPTH];
  int           mcyc  [DEPTH];
  int           mcnt = 0;
  int           cyc  = 0;
  int           ovr  = 0;
  int           acc [NP] = '{0, 0, 0, 0};

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < NP; p++) rd[p] <= rd[p] + (take[p] ? 1 : 0);
  end

  always @(negedge aclk) begin
    take <= in_tvalid & in_tready;
    if (!areset) begin
      for (int p = 0; p < NP; p++) begin
        if (in_tvalid[p] && in_tready[p]) acc[p] <= acc[p] + 1;
      end
      if (oversize_event) ovr <= ovr + 1;
      if (out_tvalid && out_tready && mcnt < DEPTH) begin
        md[mcnt]    <= out_tdata;
        mtid[mcnt]  <= out_tid;
        muser[mcnt] <= out_tuser;
        mlast[mcnt] <= out_tlast;
        mdest[mcnt] <= out_tdest[0];
        mcyc[mcnt]  <= cyc;
        mcnt        <= mcnt + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push(input int p, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      sd[p][wr[p] % DEPTH] = base + 64'(i);
      sl[p][wr[p] % DEPTH] = (i == n - 1);
      wr[p] = wr[p] + 1;
    end
  endtask

  initial begin
    int b, c0, a, o;
    logic pat [10];
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    areset = 1'b1; out_tready = 1'b1; port_enable = 4'hF;
    tick(2);
    check("rst_tready", 64'(in_tready), 64'h0);
    check("rst_out_tvalid", 64'(out_tvalid), 64'h0);
    check("rst_oversize", 64'(oversize_event), 64'h0);
    areset = 1'b0;
    tick(1);

    // Port 2, 3-beat packet
    b = mcnt; c0 = cyc;
    push(2, 3, 64'h200);
    tick(8);
    check("t1_count", 64'(mcnt - b), 64'd3);
    check("t1_data0", md[b], 64'h200);
    check("t1_data2", md[b+2], 64'h202);
    check("t1_tid", 64'(mtid[b]), 64'd2);
    check("t1_tuser", 64'(muser[b]), 64'h4);
    check("t1_tdest", 64'(mdest[b]), 64'h1);
    check("t1_last_b2", 64'(mlast[b+1]), 64'h0);
    check("t1_last_b3", 64'(mlast[b+2]), 64'h1);
    check("t1_latency", 64'(mcyc[b] - c0), 64'd1);
    check("t1_bubble_free", 64'(mcyc[b+2] - mcyc[b]), 64'd2);

    // All ports continuously valid, single-beat packets, from reset
    areset = 1'b1; tick(2); areset = 1'b0; tick(1);
    b = mcnt;
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < NP; p++) push(p, 1, 64'(p * 16 + n));
    tick(20);
    check("t2_count", 64'(mcnt - b), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_tid%0d", k), 64'(mtid[b+k]), 64'(k % 4));
      check($sformatf("t2_data%0d", k), md[b+k], 64'((k % 4) * 16 + k / 4));
      if (k > 0) check($sformatf("t2_gap%0d", k), 64'(mcyc[b+k] - mcyc[b+k-1]), 64'd2);
    end

    // Disabled port 1 is drained
    port_enable = 4'b1101;
    b = mcnt; a = acc[1];
    push(1, 4, 64'h1000);
    tick(8);
    check("t3_drained", 64'(acc[1] - a), 64'd4);
    check("t3_no_output", 64'(mcnt - b), 64'd0);
    check("t3_idle_tready", 64'(in_tready), 64'h0);
    check("t3_idle_tvalid", 64'(out_tvalid), 64'h0);
    port_enable = 4'hF;

    // Downstream backpressure on port 0
    b = mcnt;
    push(0, 4, 64'h500);
    for (int k = 0; k < 10; k++) begin
      out_tready = pat[k];
      #1;
      if (!pat[k]) begin
        check($sformatf("t4_stall_valid%0d", k), 64'(out_tvalid), 64'h1);
        check($sformatf("t4_stall_data%0d", k), out_tdata, 64'h501);
      end
      tick(1);
    end
    out_tready = 1'b1;
    check("t4_count", 64'(mcnt - b), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t4_data%0d", k), md[b+k], 64'h500 + 64'(k));
    check("t4_last", 64'(mlast[b+3]), 64'h1);
    check("t4_stall_gap", 64'(mcyc[b+1] - mcyc[b]), 64'd3);

    // Port 3, 12 beats of 8 bytes against a 64-byte limit
    b = mcnt; a = acc[3]; o = ovr;
    push(3, 12, 64'h3000);
    tick(20);
    check("t5_accepted", 64'(acc[3] - a), 64'd12);
`ifdef MAC_ARB_OVERSIZE_TRUNC_EN
    check("t5_count", 64'(mcnt - b), 64'd8);
    check("t5_last7", 64'(mlast[b+6]), 64'h0);
    check("t5_last8", 64'(mlast[b+7]), 64'h1);
    check("t5_data8", md[b+7], 64'h3007);
    check("t5_oversize", 64'(ovr - o), 64'd1);
`else
    check("t5_count", 64'(mcnt - b), 64'd12);
    check("t5_last11", 64'(mlast[b+10]), 64'h0);
    check("t5_last12", 64'(mlast[b+11]), 64'h1);
    check("t5_oversize", 64'(ovr - o), 64'd0);
`endif

    // Reset mid-packet restores port 0 priority
    push(0, 1, 64'h600);
    tick(4);
    push(0, 5, 64'h700);
    tick(2);
    check("t6_mid_valid", 64'(out_tvalid), 64'h1);
    check("t6_mid_data", out_tdata, 64'h701);
    areset = 1'b1;
    tick(1);
    check("t6_rst_tready", 64'(in_tready), 64'h0);
    check("t6_rst_tvalid", 64'(out_tvalid), 64'h0);
    for (int p = 0; p < NP; p++) wr[p] = rd[p];
    tick(1);
    areset = 1'b0;
    b = mcnt;
    push(1, 1, 64'h801);
    push(0, 1, 64'h800);
    tick(6);
    check("t6_count", 64'(mcnt - b), 64'd2);
    check("t6_first_tid", 64'(mtid[b]), 64'd0);
    check("t6_second_tid", 64'(mtid[b+1]), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_ingress_arbiter.md
# mac_ingress_arbiter

Packet-granular round-robin arbiter that merges the per-tenant ingress AXI streams into the single input of the MAC parser. It sits immediately upstream of the parser. It stamps each forwarded packet with the winning port's index on `tid` and its one-hot code on `tuser`, which matches the parser's `MAC_TUSER_IN_WIDTH = 2**AXIS_ID_WIDTH` input. Packets from ports masked off by configuration are drained and discarded, so an idle or disabled tenant never stalls the shared parser.

## Interface
- `AXIS_BUS_WIDTH`, 64, data width in bits; `NUM_BUS_BYTES = AXIS_BUS_WIDTH/8`.
- `AXIS_ID_WIDTH`, 2, port index width; `NUM_PORTS = 2**AXIS_ID_WIDTH`.
- `AXIS_DEST_WIDTH`, 0, tdest width; effective width is `max(1, AXIS_DEST_WIDTH)`.
- `MAX_PACKET_LENGTH`, 1522, maximum legal packet length in bytes (used only when truncation is compiled in).
- `aclk`  in  1  single clock; all logic is rising-edge.
- `areset`  in  1  synchronous, active-high reset.
- `axis_in_tdata`  in  NUM_PORTS*AXIS_BUS_WIDTH  packed per port; port p occupies slice p.
- `axis_in_tdest`  in  NUM_PORTS*EFF_DEST_WIDTH  packed per port.
- `axis_in_tkeep`  in  NUM_PORTS*NUM_BUS_BYTES  packed per port.
- `axis_in_tlast`, `axis_in_tvalid`  in  NUM_PORTS  one bit per port.
- `axis_in_tready`  out  NUM_PORTS  one bit per port.
- `axis_out_tdata`  out  AXIS_BUS_WIDTH; `axis_out_tkeep`  out  NUM_BUS_BYTES; `axis_out_tdest`  out  EFF_DEST_WIDTH.
- `axis_out_tuser`  out  NUM_PORTS  one-hot code of the granted port.
- `axis_out_tid`  out  max(1,AXIS_ID_WIDTH)  binary index of the granted port.
- `axis_out_tlast`, `axis_out_tvalid`  out  1; `axis_out_tready`  in  1.
- `port_enable`  in  NUM_PORTS  per-port forward enable, sampled only at grant time.
- `oversize_event`  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States: IDLE, FWD, DRAIN. `grant` is a registered index; `last_grant` is the round-robin pointer.
- IDLE:
  - Candidates are all ports with `tvalid=1`, whether enabled or not.
  - The winner is the first candidate found scanning upward from `last_grant+1`, modulo NUM_PORTS.
  - The winner is registered into `grant`.
  - If `port_enable[winner]` is 1, the next state is FWD; otherwise it is DRAIN.
  - With no candidates, the block stays in IDLE.
  - All `axis_in_tready` are 0 in IDLE.
- FWD:
  - Outputs are driven combinationally from slice `grant`: tdata, tkeep, tdest, tlast, tvalid.
  - `tuser = 1<<grant`; `tid = grant`.
  - `axis_in_tready[grant] = axis_out_tready`; all other treadys are 0.
  - On an accepted beat with `tlast=1`: `last_grant <= grant`, next state IDLE.
- DRAIN:
  - `axis_in_tready[grant] = 1`; `axis_out_tvalid = 0`.
  - On an accepted beat with `tlast=1`: `last_grant <= grant`, next state IDLE.
- `port_enable` changes take effect only at the next IDLE arbitration. A packet already in FWD always completes.
- Fairness: a port that is continuously valid is granted again only after every other valid port has had one packet.

## Timing
- Reset values:
  - state = IDLE and `last_grant = NUM_PORTS-1`, so port 0 has first priority.
  - `grant = 0`; byte counter = 0.
  - All `axis_in_tready` = 0; `axis_out_tvalid` = 0; `oversize_event` = 0.
  - Data outputs are don't-care while `tvalid` = 0.
- Arbitration costs exactly one IDLE cycle per packet. The first beat of the granted packet can appear on the output in the cycle after the request is seen.
- FWD is zero-latency and bubble-free: one beat passes per cycle while `axis_out_tready=1`.
- `axis_out_tvalid` and data stay stable while `tready=0`; this follows from the upstream AXIS rules.
- A single-beat packet (`tlast` on the first beat) returns to IDLE after one FWD cycle.
- Reset asserted mid-packet: the state returns to IDLE immediately and the downstream sees a packet without tlast. Upstream is reset by the same `areset`.

## Configuration
- `MAC_ARB_OVERSIZE_TRUNC_EN` defined:
  - A byte counter of width `$clog2(MAX_PACKET_LENGTH+NUM_BUS_BYTES+1)` accumulates `popcount(tkeep)` on each accepted FWD beat. It clears on entry to FWD.
  - Truncation condition: an accepted beat would bring the count to ≥ MAX_PACKET_LENGTH and its input `tlast=0`.
  - When the condition holds, that beat is emitted with `axis_out_tlast=1` and `oversize_event` pulses in the same cycle.
  - The next state is then DRAIN, which discards the remainder of the packet through its input tlast.
  - `last_grant` updates when DRAIN finishes.
- Macro undefined: there is no counter, `oversize_event` is tied 0, and packets pass at any length.

## Test plan
- Reset, then port 2 sends a 3-beat packet with tkeep=0xFF → out tid=2, tuser=0b0100, 3 beats, tlast on beat 3; the first output beat appears 1 cycle after the first valid.
- All 4 ports valid continuously with 1-beat packets → grant order 0,1,2,3,0,1…, with one IDLE cycle between packets.
- `port_enable=0b1101`, port 1 sends a 4-beat packet → port 1 tready is high for 4 cycles, no output beats, then the block is back in IDLE.
- Port 0 mid-packet with `axis_out_tready` toggling 1,0,0,1 → no beat is lost or duplicated, and the output stays stable while stalled.
- `MAC_ARB_OVERSIZE_TRUNC_EN` defined, MAX_PACKET_LENGTH=64, port 3 sends a 12-beat packet with full tkeep → 8 beats out, tlast on beat 8, one `oversize_event` pulse, and 4 beats drained.
- `areset` asserted on beat 2 of a 5-beat FWD packet → next cycle all treadys are 0, out tvalid is 0, and port 0 has first priority again.
